// File: rtl/product_bcd_converter.sv
// product_bcd_converter
//   Takes the signed product from the sequential multiplier when its Ready
//   level rises and turns the magnitude into packed BCD for the seven-segment
//   driver. It uses the shift-add-3 (double dabble) method and converts one
//   product bit per clock. The sign and the multiplier overflow flag are
//   carried along with the result. bcd/sign/ovf update only once a conversion
//   has finished, so the display never shows a partial value.
//
// Parameters
//   LENGTH  multiplier operand width; the product is 2*LENGTH bits wide
//   DIGITS  number of BCD digits; needs 10**DIGITS > 2**(2*LENGTH-1)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   ready_in     in   multiplier Ready level; a 0->1 transition starts a conversion
//   product      in   signed two's-complement product (2*LENGTH bits)
//   overflow_in  in   multiplier overflow flag, sampled together with product
//   bcd          out  packed BCD magnitude; digit 0 (units) is bits [3:0]
//   sign         out  1 when the captured product was negative
//   ovf          out  overflow flag that belongs to the displayed result
//   busy         out  high from the capture edge until the result is delivered
//   done         out  one-cycle pulse when bcd/sign/ovf have just been updated
module product_bcd_converter #(
    parameter int LENGTH = 5,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready_in,
    input  logic [2*LENGTH-1:0]   product,
    input  logic                  overflow_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int P_W    = 2 * LENGTH;
    localparam int B_W    = 4 * DIGITS;
    localparam int SHIFTS = P_W;
    localparam int CNT_W  = $clog2(SHIFTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               ready_d;
    logic               start_ev;
    logic [P_W-1:0]     mag;
    logic [B_W-1:0]     bcd_acc;
    logic [B_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               sign_r;
    logic               ovf_r;

    // Adds 3 to every BCD digit that is 5 or more. After the next left shift
    // that digit then carries correctly into the digit above it.
    function automatic logic [B_W-1:0] add3(input logic [B_W-1:0] v);
        logic [B_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Two's-complement magnitude. The result is treated as unsigned, so the
    // most negative product maps to 2**(P_W-1) with no overflow.
    function automatic logic [P_W-1:0] magnitude(input logic [P_W-1:0] p);
        return p[P_W-1] ? (~p + P_W'(1)) : p;
    endfunction

    assign start_ev = ready_in & ~ready_d;
    assign bcd_adj  = add3(bcd_acc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start event is accepted only in IDLE. Rises during SHIFT or DONE are
    // dropped and are not held for later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ev) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_d <= 1'b0;
            mag     <= '0;
            bcd_acc <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            ovf_r   <= 1'b0;
            bcd     <= '0;
            sign    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ready_d <= ready_in;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ev) begin
                        mag     <= magnitude(product);
                        sign_r  <= product[P_W-1];
                        ovf_r   <= overflow_in;
                        bcd_acc <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // {bcd_acc, mag} shifts left by one bit after the digit adjust.
                    bcd_acc <= {bcd_adj[B_W-2:0], mag[P_W-1]};
                    mag     <= {mag[P_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd  <= bcd_acc;
                    sign <= sign_r;
                    ovf  <= ovf_r;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

    localparam int LENGTH = 5;
    localparam int DIGITS = 4;
    localparam int P_W    = 2 * LENGTH;
    localparam int B_W    = 4 * DIGITS;

    logic             clock;
    logic             reset;
    logic             ready_in;
    logic [P_W-1:0]   product;
    logic             overflow_in;
    logic [B_W-1:0]   bcd;
    logic             sign;
    logic             ovf;
    logic             busy;
    logic             done;

    product_bcd_converter #(.LENGTH(LENGTH), .DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .ready_in    (ready_in),
        .product     (product),
        .overflow_in (overflow_in),
        .bcd         (bcd),
        .sign        (sign),
        .ovf         (ovf),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [P_W-1:0] p;
        logic           ov;
        logic [B_W-1:0] eb;
        logic           es;
        logic           eo;
    } vec_t;

    typedef struct {
        logic [B_W-1:0] eb;
        logic           es;
        logic           eo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference conversion by decimal division. It does not use the RTL's method.
    function automatic logic [B_W-1:0] to_bcd(input int m);
        logic [B_W-1:0] r;
        int v;
        r = '0;
        v = m;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic vec_t model(input int val, input logic ov);
        vec_t v;
        v.p  = P_W'(val);
        v.ov = ov;
        v.es = (val < 0);
        v.eb = to_bcd(val < 0 ? -val : val);
        v.eo = ov;
        return v;
    endfunction

    // Scoreboard side: each done pulse pops one expected result.
    always @(negedge clock) begin
        if (reset && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 bcd=%h required no done", bcd);
            end else begin
                e = sb.pop_front();
                check("bcd", int'(bcd), int'(e.eb));
                check("sign", int'(sign), int'(e.es));
                check("ovf", int'(ovf), int'(e.eo));
            end
        end
    end

    task automatic push(input logic [B_W-1:0] eb, input logic es, input logic eo);
        exp_t e;
        e.eb = eb;
        e.es = es;
        e.eo = eo;
        sb.push_back(e);
    endtask

    // Waits for done. It returns the number of negedges waited and how many
    // of them had busy high. An expired bound counts as a failure.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cyc++;
            if (busy) bcnt++;
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no done after %0d cycles required done", cyc);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int bcnt;
        @(negedge clock);
        product     = v.p;
        overflow_in = v.ov;
        ready_in    = 1'b1;
        push(v.eb, v.es, v.eo);
        wait_done(cyc, bcnt);
        check({tag, "_latency"}, cyc, 2 * LENGTH + 2);
        check({tag, "_busy_len"}, bcnt, 2 * LENGTH + 1);
        ready_in = 1'b0;
        @(negedge clock);
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        int bcnt;
        int d0;
        int r;

        reset       = 1'b0;
        ready_in    = 1'b0;
        product     = '0;
        overflow_in = 1'b0;

        vecs.push_back('{10'd0,   1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{10'h310, 1'b0, 16'h0240, 1'b1, 1'b0});
        vecs.push_back('{10'h200, 1'b1, 16'h0512, 1'b1, 1'b1});
        vecs.push_back('{10'd511, 1'b0, 16'h0511, 1'b0, 1'b0});
        vecs.push_back('{10'h3FF, 1'b0, 16'h0001, 1'b1, 1'b0});
        vecs.push_back('{10'd256, 1'b0, 16'h0256, 1'b0, 1'b0});
        vecs.push_back('{10'd7,   1'b1, 16'h0007, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(1023)) - 512;
            vecs.push_back(model(r, 1'($urandom_range(1))));
        end

        repeat (3) @(negedge clock);
        check("rst_bcd", int'(bcd), 0);
        check("rst_sign", int'(sign), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Second rise 4 clocks after the first must be ignored.
        d0 = done_cnt;
        product  = 10'd256;
        ready_in = 1'b1;
        push(16'h0256, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        ready_in = 1'b0;
        product  = 10'd5;
        repeat (2) @(negedge clock);
        ready_in = 1'b1;
        repeat (30) @(negedge clock);
        check("double_rise_dones", done_cnt - d0, 1);
        ready_in = 1'b0;
        repeat (2) @(negedge clock);

        // Rise that lands on the DONE->IDLE edge must be ignored.
        d0 = done_cnt;
        product  = 10'd123;
        ready_in = 1'b1;
        push(16'h0123, 1'b0, 1'b0);
        @(negedge clock);
        ready_in = 1'b0;
        repeat (10) @(negedge clock);
        ready_in = 1'b1;
        product  = 10'd9;
        repeat (30) @(negedge clock);
        check("done_edge_rise_dones", done_cnt - d0, 1);
        ready_in = 1'b0;
        repeat (2) @(negedge clock);

        // Reset in the middle of SHIFT clears everything at once and gives no done.
        check("pre_reset_bcd_nonzero", int'(bcd != '0), 1);
        d0 = done_cnt;
        product  = 10'h3F0;
        ready_in = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_bcd", int'(bcd), 0);
        check("midrst_sign", int'(sign), 0);
        check("midrst_ovf", int'(ovf), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        ready_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("midrst_no_done", done_cnt - d0, 0);

        // ready_in held high for 40 clocks gives exactly one conversion.
        d0 = done_cnt;
        product  = 10'd99;
        ready_in = 1'b1;
        push(16'h0099, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        check("held_latency", cyc, 2 * LENGTH + 2);
        repeat (40 - cyc) @(negedge clock);
        check("held_dones", done_cnt - d0, 1);
        check("held_bcd_hold", int'(bcd), 16'h0099);
        ready_in = 1'b0;
        repeat (3) @(negedge clock);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
